ipf_feeder: RTL and testbench
=============================

IPF_FEEDER -- requirements
Module: ipf_feeder

Interface
REQ-001 clk  in  1  sole clock, rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  one-cycle job request, sampled at posedge.
REQ-004 cfg_wsize  in  2  kernel size: 0=3x3, 1=5x5, 2=7x7, 3=reserved.
REQ-005 cfg_ngroups  in  4  weight groups per job, 1..15; 0 is illegal.
REQ-006 w_rd / w_addr  out  1 / 5  weight-buffer read strobe and address.
REQ-007 w_rdata  in  64  weight word, valid one cycle after w_rd.
REQ-008 i_rd / i_addr  out  1 / 3  input-buffer read strobe and address.
REQ-009 i_rdata  in  64  input word, valid one cycle after i_rd.
REQ-010 w_valid / w_data  out  1 / 64  weight stream to IPF.
REQ-011 i_valid / i_data  out  1 / 64  input stream to IPF.
REQ-012 ctrl  out  2  IPF control: 0=end, 1=start, 2=hold.
REQ-013 Wsize / wgroup  out  2 / 4  IPF kernel size and current group index.
REQ-014 busy / done / err  out  1 each  job active / one-cycle completion / one-cycle config-reject pulse.

Function
REQ-015 States SHALL be IDLE, WLOAD, IFEED, FIN.
REQ-016 IDLE SHALL accept start only when cfg_wsize!=3 and cfg_ngroups!=0; it SHALL latch cfg into Wsize, clear wgroup, set busy and go to WLOAD.
REQ-017 A start with an illegal cfg SHALL pulse err the next cycle and remain in IDLE.
REQ-018 start while busy SHALL be ignored, with no err.
REQ-019 Weight count NW SHALL be 18/25/25 and preload count P SHALL be 2/4/6 for Wsize 0/1/2.
REQ-020 WLOAD SHALL assert w_rd for NW consecutive cycles with w_addr 0..NW-1, then enter IFEED.
REQ-021 w_valid SHALL assert exactly one cycle after each w_rd, with w_data=w_rdata (registered, no gaps).
REQ-022 IFEED SHALL assert i_rd for 16 consecutive cycles per group, with i_addr=k mod 8 for k=0..15; groups SHALL run back-to-back with no idle cycle.
REQ-023 i_valid/i_data SHALL follow i_rd by exactly one cycle.
REQ-024 ctrl SHALL be cycle-aligned with i_valid: 2 (hold) for words k<P and 1 (start) for k>=P of each group.
REQ-025 wgroup SHALL equal the group index of the word currently on i_data and increment only at group boundaries.
REQ-026 After the last group, FIN SHALL drive ctrl=0 and pulse done for one cycle aligned with it, clear busy that cycle, then return to IDLE.
REQ-027 In IDLE, WLOAD and FIN, ctrl SHALL be 0, except that ctrl SHALL be 2 while w_valid is high.
REQ-028 Latency: with start sampled at cycle 0, the first w_rd SHALL occur at cycle 1, the first w_valid at cycle 2, the first i_valid at cycle NW+2, and done at cycle NW+2+16*ngroups.
REQ-029 w_valid and i_valid SHALL never be high in the same cycle.

Reset
REQ-030 While rst=0, all outputs SHALL be 0 (ctrl=0, Wsize=0, wgroup=0, data=0), state SHALL be IDLE, and latched cfg SHALL be cleared.
REQ-031 Reset asserted mid-job SHALL abort immediately with no done pulse; the first start after release SHALL begin a fresh job.

Structure
REQ-032 Package ipf_pkg SHALL hold the ctrl encodings (CTRL_END=0, CTRL_START=1, CTRL_HOLD=2), the state enum, and the NW/P lookup tables indexed by Wsize.
REQ-033 The block SHALL be a single module with no sub-module: one FSM, one word counter (5 bits), and one group counter (4 bits).

Verification
REQ-034 3x3, ngroups=2, buffer returns address as data -> 18 w_valid words (data 0..17) in cycles 2..19; 32 i_valid words (data 0..7 repeating) in cycles 20..51; ctrl=2,2,1x14 per group; wgroup=0 then 1; done and ctrl=0 at cycle 52.
REQ-035 5x5, ngroups=1 -> 25 weight words; i words 0-3 with ctrl=2, words 4-15 with ctrl=1; done at cycle 43.
REQ-036 7x7, ngroups=3 -> P=6 hold words per group; wgroup 0,1,2; done at cycle 75.
REQ-037 start with cfg_wsize=3, then a separate start with cfg_ngroups=0 -> err pulse for each; busy stays 0; no rd strobes.
REQ-038 start pulsed at cycle 10 of a running job -> ignored; timeline identical to REQ-034.
REQ-039 rst low at cycle 25 of the REQ-034 job -> all outputs 0 at once, no done; a new start completes normally.

Source files
------------

// File: rtl/ipf_pkg.sv
// Shared encodings and per-kernel-size lookup tables for the IPF feeder.
package ipf_pkg;

    localparam logic [1:0] CTRL_END   = 2'd0;
    localparam logic [1:0] CTRL_START = 2'd1;
    localparam logic [1:0] CTRL_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WLOAD = 2'd1,
        S_IFEED = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // Indexed by Wsize: 0=3x3, 1=5x5, 2=7x7, 3=reserved
    localparam logic [4:0] NW_TAB [4] = '{5'd18, 5'd25, 5'd25, 5'd0};
    localparam logic [3:0] P_TAB  [4] = '{4'd2, 4'd4, 4'd6, 4'd0};

endpackage

// File: rtl/ipf_feeder.sv
// Streams a kernel's weights, then 16 input words per group, into the IPF.
// Read strobes go out one cycle ahead of the matching valid/data/ctrl.
module ipf_feeder
    import ipf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  cfg_wsize,
    input  logic [3:0]  cfg_ngroups,
    output logic        w_rd,
    output logic [4:0]  w_addr,
    input  logic [63:0] w_rdata,
    output logic        i_rd,
    output logic [2:0]  i_addr,
    input  logic [63:0] i_rdata,
    output logic        w_valid,
    output logic [63:0] w_data,
    output logic        i_valid,
    output logic [63:0] i_data,
    output logic [1:0]  ctrl,
    output logic [1:0]  Wsize,
    output logic [3:0]  wgroup,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [3:0]  grp;
    logic [3:0]  ngroups;
    logic [3:0]  pos;
    logic [4:0]  nw;
    logic [3:0]  npre;
    logic        cfg_ok;
    logic        accept;

    assign cfg_ok = (cfg_wsize != 2'd3) && (cfg_ngroups != 4'd0);
    assign accept = (state == S_IDLE) && start && cfg_ok;
    assign nw     = NW_TAB[Wsize];
    assign npre   = P_TAB[Wsize];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_WLOAD;
            S_WLOAD: if (cnt == nw - 5'd1) state_nxt = S_IFEED;
            S_IFEED: if (cnt == 5'd15 && grp == ngroups - 4'd1) state_nxt = S_FIN;
            // FIN first drains the last input word, then reports done
            S_FIN:   if (!i_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            grp     <= '0;
            Wsize   <= '0;
            ngroups <= '0;
            wgroup  <= '0;
            pos     <= '0;
            w_valid <= 1'b0;
            i_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            err     <= start && (state == S_IDLE) && !cfg_ok;
            w_valid <= w_rd;
            i_valid <= i_rd;
            if (i_rd) begin
                wgroup <= grp;
                pos    <= cnt[3:0];
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        Wsize   <= cfg_wsize;
                        ngroups <= cfg_ngroups;
                        wgroup  <= '0;
                        cnt     <= '0;
                        grp     <= '0;
                    end
                end
                S_WLOAD: cnt <= (cnt == nw - 5'd1) ? 5'd0 : cnt + 5'd1;
                S_IFEED: begin
                    if (cnt == 5'd15) begin
                        cnt <= '0;
                        grp <= grp + 4'd1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    cnt <= '0;
                    grp <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_rd   = (state == S_WLOAD);
        w_addr = w_rd ? cnt : 5'd0;
        i_rd   = (state == S_IFEED);
        i_addr = i_rd ? cnt[2:0] : 3'd0;
        done   = (state == S_FIN) && !i_valid;
        busy   = (state != S_IDLE) && !done;
        w_data = w_valid ? w_rdata : 64'd0;
        i_data = i_valid ? i_rdata : 64'd0;
        ctrl   = CTRL_END;
        if (i_valid) begin
            ctrl = (pos < npre) ? CTRL_HOLD : CTRL_START;
        end else if (w_valid) begin
            ctrl = CTRL_HOLD;
        end
    end

endmodule

// File: tb/tb_ipf_feeder.sv
// Directed bench for ipf_feeder: address-as-data buffers, per-cycle timeline model.
module tb_ipf_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cfg_wsize = 2'd0;
    logic [3:0]  cfg_ngroups = 4'd0;
    logic        w_rd;
    logic [4:0]  w_addr;
    logic [63:0] w_rdata = 64'd0;
    logic        i_rd;
    logic [2:0]  i_addr;
    logic [63:0] i_rdata = 64'd0;
    logic        w_valid;
    logic [63:0] w_data;
    logic        i_valid;
    logic [63:0] i_data;
    logic [1:0]  ctrl;
    logic [1:0]  Wsize;
    logic [3:0]  wgroup;
    logic        busy;
    logic        done;
    logic        err;

    int nvec = 0;
    int nbad = 0;

    ipf_feeder dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_wsize(cfg_wsize), .cfg_ngroups(cfg_ngroups),
        .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
        .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata),
        .w_valid(w_valid), .w_data(w_data),
        .i_valid(i_valid), .i_data(i_data),
        .ctrl(ctrl), .Wsize(Wsize), .wgroup(wgroup),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Buffers return their read address as data, one cycle after the strobe
    always @(posedge clk) begin
        if (w_rd) w_rdata <= 64'(w_addr);
        if (i_rd) i_rdata <= 64'(i_addr);
    end

    function automatic logic [22:0] pk(input logic a_wrd, input logic [4:0] a_waddr,
                                       input logic a_ird, input logic [2:0] a_iaddr,
                                       input logic a_wv, input logic a_iv,
                                       input logic [1:0] a_ctrl, input logic [1:0] a_ws,
                                       input logic [3:0] a_wg, input logic a_busy,
                                       input logic a_done, input logic a_err);
        return {a_wrd, a_waddr, a_ird, a_iaddr, a_wv, a_iv, a_ctrl, a_ws, a_wg,
                a_busy, a_done, a_err};
    endfunction

    function automatic logic [22:0] obs_ctl();
        return pk(w_rd, w_addr, i_rd, i_addr, w_valid, i_valid, ctrl, Wsize, wgroup,
                  busy, done, err);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'(obs_ctl()), 64'd0);
        chk({tag, "_wd"}, w_data, 64'd0);
        chk({tag, "_id"}, i_data, 64'd0);
    endtask

    // inj: cycle at which a stray start (with a reserved size) is pulsed; 0 = none
    // abort_at: cycle at which reset is asserted mid-job; 0 = none
    task automatic run_job(input int ws, input int ng, input int inj, input int abort_at);
        int nw, p, d, j, k, g;
        logic e_wrd, e_ird, e_wv, e_iv, e_busy, e_done;
        logic [4:0] e_waddr;
        logic [2:0] e_iaddr;
        logic [1:0] e_ctrl;
        logic [3:0] e_wg;
        logic [63:0] e_wd, e_id;
        nw = (ws == 0) ? 18 : 25;
        p  = (ws == 0) ? 2 : (ws == 1) ? 4 : 6;
        d  = nw + 2 + 16 * ng;
        @(negedge clk);
        cfg_wsize   = 2'(ws);
        cfg_ngroups = 4'(ng);
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= d + 2; c++) begin
            if (c == abort_at) begin
                rst = 1'b0;
                #1;
                chk_all_zero($sformatf("abort_c%0d", c));
                break;
            end
            if (inj != 0 && c == inj) begin
                start = 1'b1;
                cfg_wsize = 2'd3;
            end
            if (inj != 0 && c == inj + 1) begin
                start = 1'b0;
                cfg_wsize = 2'(ws);
            end
            @(negedge clk);
            e_wrd   = (c >= 1 && c <= nw);
            e_waddr = e_wrd ? 5'(c - 1) : 5'd0;
            e_ird   = (c >= nw + 1 && c <= nw + 16 * ng);
            e_iaddr = e_ird ? 3'((c - nw - 1) % 8) : 3'd0;
            e_wv    = (c >= 2 && c <= nw + 1);
            e_wd    = e_wv ? 64'(c - 2) : 64'd0;
            e_iv    = (c >= nw + 2 && c <= nw + 1 + 16 * ng);
            j       = c - nw - 2;
            k       = (j >= 0) ? j % 16 : 0;
            g       = (j >= 0) ? j / 16 : 0;
            e_id    = e_iv ? 64'(k % 8) : 64'd0;
            e_ctrl  = e_iv ? ((k < p) ? 2'd2 : 2'd1) : (e_wv ? 2'd2 : 2'd0);
            e_wg    = (c < nw + 2) ? 4'd0 : (e_iv ? 4'(g) : 4'(ng - 1));
            e_busy  = (c <= d - 1);
            e_done  = (c == d);
            chk($sformatf("ctl_ws%0d_c%0d", ws, c), 64'(obs_ctl()),
                64'(pk(e_wrd, e_waddr, e_ird, e_iaddr, e_wv, e_iv, e_ctrl, 2'(ws), e_wg,
                       e_busy, e_done, 1'b0)));
            chk($sformatf("wdat_ws%0d_c%0d", ws, c), w_data, e_wd);
            chk($sformatf("idat_ws%0d_c%0d", ws, c), i_data, e_id);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_reject(input int ws, input int ng);
        @(negedge clk);
        cfg_wsize   = 2'(ws);
        cfg_ngroups = 4'(ng);
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk($sformatf("err_ws%0d_ng%0d", ws, ng), 64'(obs_ctl()),
            64'(pk(1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1)));
        @(negedge clk);
        chk($sformatf("err_end_ws%0d_ng%0d", ws, ng), 64'(obs_ctl()), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        cfg_reject(3, 2);
        cfg_reject(0, 0);

        run_job(0, 2, 0, 0);
        run_job(1, 1, 0, 0);
        run_job(2, 3, 0, 0);
        run_job(0, 2, 10, 0);

        run_job(0, 2, 0, 25);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero($sformatf("inrst_%0d", i));
        end
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("post_rst");
        run_job(0, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
